// File: rtl/vga_frame_capture.sv
// Video capture stage: recovers raster position from the syncs, measures line/frame size,
// and streams windowed pixels with coordinates through a small show-ahead valid/ready FIFO.
module vga_frame_capture #(
   parameter logic SYNC_POL   = 1'b0,
   parameter int   H_START    = 144,
   parameter int   H_WIDTH    = 640,
   parameter int   V_START    = 40,
   parameter int   V_HEIGHT   = 480,
   parameter int   FIFO_DEPTH = 4
) (
   input  logic        fclk,
   input  logic        rst,
   input  logic        vhsync,
   input  logic        vvsync,
   input  logic [1:0]  vred,
   input  logic [1:0]  vgrn,
   input  logic [1:0]  vblu,
   input  logic        pix_ready,
   output logic        pix_valid,
   output logic [5:0]  pix_data,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        pix_sof,
   output logic [11:0] line_len,
   output logic [10:0] frame_lines,
   output logic        meas_stb,
   output logic        overflow
);

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int ENTRY_W = 27;

   localparam logic [11:0]    H_LO     = H_START[11:0];
   localparam logic [11:0]    H_HI     = 12'(H_START + H_WIDTH);
   localparam logic [10:0]    V_LO     = V_START[10:0];
   localparam logic [10:0]    V_HI     = 11'(V_START + V_HEIGHT);
   localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

   // ------------------------------------------------------------------
   // Input register stage
   // ------------------------------------------------------------------
   logic       hs_reg;
   logic       vs_reg;
   logic [5:0] rgb_reg;

   // Syncs reset to their inactive level so reset release cannot fake an edge.
   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         hs_reg  <= ~SYNC_POL;
         vs_reg  <= ~SYNC_POL;
         rgb_reg <= '0;
      end else begin
         hs_reg  <= vhsync;
         vs_reg  <= vvsync;
         rgb_reg <= {vred, vgrn, vblu};
      end
   end

   // ------------------------------------------------------------------
   // Sync edge detection and raster counters
   // ------------------------------------------------------------------
   logic        hs_act;
   logic        vs_act;
   logic        hs_act_prev_reg;
   logic        vs_act_prev_reg;
   logic        hs_edge;
   logic        vs_edge;

   logic [11:0] hcnt_reg;
   logic [11:0] hcnt_next;
   logic [10:0] vcnt_reg;
   logic [10:0] vcnt_next;
   logic [11:0] line_len_reg;
   logic [11:0] line_len_next;
   logic [10:0] frame_lines_reg;
   logic [10:0] frame_lines_next;
   logic        meas_stb_reg;
   logic        meas_stb_next;
   logic        synced_reg;
   logic        synced_next;

   assign hs_act  = (hs_reg == SYNC_POL);
   assign vs_act  = (vs_reg == SYNC_POL);
   assign hs_edge = hs_act & ~hs_act_prev_reg;
   assign vs_edge = vs_act & ~vs_act_prev_reg;

   always_comb begin
      hcnt_next        = (hcnt_reg == 12'hFFF) ? hcnt_reg : hcnt_reg + 12'd1;
      line_len_next    = line_len_reg;
      vcnt_next        = vcnt_reg;
      frame_lines_next = frame_lines_reg;
      meas_stb_next    = 1'b0;
      synced_next      = synced_reg;

      if (hs_edge) begin
         hcnt_next     = '0;
         line_len_next = (hcnt_reg == 12'hFFF) ? hcnt_reg : hcnt_reg + 12'd1;
      end

      // A vsync edge overrides the line increment from a coincident hsync edge.
      if (vs_edge) begin
         frame_lines_next = vcnt_reg;
         vcnt_next        = '0;
         meas_stb_next    = 1'b1;
         synced_next      = 1'b1;
      end else if (hs_edge && vcnt_reg != 11'h7FF) begin
         vcnt_next = vcnt_reg + 11'd1;
      end
   end

   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         hs_act_prev_reg <= 1'b0;
         vs_act_prev_reg <= 1'b0;
         hcnt_reg        <= '0;
         vcnt_reg        <= '0;
         line_len_reg    <= '0;
         frame_lines_reg <= '0;
         meas_stb_reg    <= 1'b0;
         synced_reg      <= 1'b0;
      end else begin
         hs_act_prev_reg <= hs_act;
         vs_act_prev_reg <= vs_act;
         hcnt_reg        <= hcnt_next;
         vcnt_reg        <= vcnt_next;
         line_len_reg    <= line_len_next;
         frame_lines_reg <= frame_lines_next;
         meas_stb_reg    <= meas_stb_next;
         synced_reg      <= synced_next;
      end
   end

   // ------------------------------------------------------------------
   // Capture window
   // ------------------------------------------------------------------
   logic               in_h;
   logic               in_v;
   logic               capture;
   logic [9:0]         cap_x;
   logic [9:0]         cap_y;
   logic               cap_sof;
   logic [ENTRY_W-1:0] wr_entry;

   assign in_h    = (hcnt_reg >= H_LO) && (hcnt_reg < H_HI);
   assign in_v    = (vcnt_reg >= V_LO) && (vcnt_reg < V_HI);
   assign capture = synced_reg & in_h & in_v & ~hs_act & ~vs_act;

   assign cap_x    = 10'(hcnt_reg - H_LO);
   assign cap_y    = 10'(vcnt_reg - V_LO);
   assign cap_sof  = (hcnt_reg == H_LO) && (vcnt_reg == V_LO);
   assign wr_entry = {cap_sof, cap_x, cap_y, rgb_reg};

   // ------------------------------------------------------------------
   // Show-ahead output FIFO
   // ------------------------------------------------------------------
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [PTR_W:0]     count_reg;
   logic [PTR_W:0]     count_next;
   logic               overflow_reg;
   logic               empty;
   logic               full;
   logic               pop;
   logic               wr_en;
   logic               drop;
   logic [ENTRY_W-1:0] mem_rd [FIFO_DEPTH];
   logic [ENTRY_W-1:0] head_entry;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == FULL_CNT);
   assign pop   = ~empty & pix_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign wr_en = capture & (~full | pop);
   assign drop  = capture & full & ~pop;

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
         logic [ENTRY_W-1:0] slot_reg;

         always_ff @(posedge fclk) begin
            if (wr_en && wr_ptr_reg == PTR_W'(gi)) begin
               slot_reg <= wr_entry;
            end
         end

         assign mem_rd[gi] = slot_reg;
      end
   endgenerate

   always_comb begin
      count_next = count_reg;
      case ({wr_en, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Slots carry no reset, so the head is masked while the FIFO is empty.
   assign head_entry = mem_rd[rd_ptr_reg];
   assign pix_valid  = ~empty;
   assign {pix_sof, pix_x, pix_y, pix_data} = empty ? '0 : head_entry;

   assign line_len    = line_len_reg;
   assign frame_lines = frame_lines_reg;
   assign meas_stb    = meas_stb_reg;
   assign overflow    = overflow_reg;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture on a scaled-down raster (100 fclk x 14 lines).
module tb_vga_frame_capture;

   localparam logic SYNC_POL   = 1'b0;
   localparam int   H_START    = 20;
   localparam int   H_WIDTH    = 64;
   localparam int   V_START    = 4;
   localparam int   V_HEIGHT   = 6;
   localparam int   FIFO_DEPTH = 4;
   localparam int   H_TOTAL    = 100;
   localparam int   HS_LEN     = 12;
   localparam int   V_TOTAL    = 14;
   localparam int   VS_LINES   = 2;

   logic        fclk = 1'b0;
   logic        rst;
   logic        vhsync;
   logic        vvsync;
   logic [1:0]  vred;
   logic [1:0]  vgrn;
   logic [1:0]  vblu;
   logic        pix_ready;
   logic        pix_valid;
   logic [5:0]  pix_data;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        pix_sof;
   logic [11:0] line_len;
   logic [10:0] frame_lines;
   logic        meas_stb;
   logic        overflow;

   vga_frame_capture #(
      .SYNC_POL   (SYNC_POL),
      .H_START    (H_START),
      .H_WIDTH    (H_WIDTH),
      .V_START    (V_START),
      .V_HEIGHT   (V_HEIGHT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .fclk        (fclk),
      .rst         (rst),
      .vhsync      (vhsync),
      .vvsync      (vvsync),
      .vred        (vred),
      .vgrn        (vgrn),
      .vblu        (vblu),
      .pix_ready   (pix_ready),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_sof     (pix_sof),
      .line_len    (line_len),
      .frame_lines (frame_lines),
      .meas_stb    (meas_stb),
      .overflow    (overflow)
   );

   always #5 fclk = ~fclk;

   int n_checks = 0;
   int n_errors = 0;

   // Raster generator position and controls
   int gh, gv, vs_off, ready_mode, rgb_mode;
   bit vs_en;

   // Reference model state
   int          m_hcnt, m_vcnt, exp_line_len;
   bit          m_synced, m_hs_prev, m_vs_prev, exp_ovf;
   logic [26:0] exp_q [$];
   bit          st1_cap, st2_cap, st1_meas, st2_meas, mon_meas, mon_pop;
   logic [26:0] st1_ent, st2_ent;
   int          st1_fl, st2_fl, mon_fl;
   int          pop_cnt, sof_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_hcnt = 0; m_vcnt = 0; m_synced = 0; m_hs_prev = 0; m_vs_prev = 0;
      exp_ovf = 0;
      st1_cap = 0; st2_cap = 0; st1_meas = 0; st2_meas = 0; mon_meas = 0;
      st1_ent = '0; st2_ent = '0; st1_fl = 0; st2_fl = 0; mon_fl = 0;
   endtask

   // Drives one video sample and advances the model to the counter state the DUT
   // will hold once this sample has passed its input register.
   task automatic drive_cycle();
      bit          hs_a, vs_a, hs_e, vs_e, cap, sof;
      int          p;
      logic [5:0]  rgb;
      p    = gv * H_TOTAL + gh;
      hs_a = (gh < HS_LEN);
      vs_a = vs_en && (p >= vs_off) && (p < vs_off + VS_LINES * H_TOTAL);
      rgb  = (rgb_mode == 0) ? m_hcnt[5:0] : 6'($urandom);
      vhsync = hs_a ? SYNC_POL : ~SYNC_POL;
      vvsync = vs_a ? SYNC_POL : ~SYNC_POL;
      {vred, vgrn, vblu} = rgb;
      case (ready_mode)
         0:       pix_ready = 1'b0;
         1:       pix_ready = 1'b1;
         default: pix_ready = (exp_q.size() == FIFO_DEPTH);
      endcase

      cap = m_synced && m_hcnt >= H_START && m_hcnt < H_START + H_WIDTH &&
            m_vcnt >= V_START && m_vcnt < V_START + V_HEIGHT && !hs_a && !vs_a;
      sof = (m_hcnt == H_START) && (m_vcnt == V_START);
      hs_e = hs_a && !m_hs_prev;
      vs_e = vs_a && !m_vs_prev;

      st2_cap = st1_cap; st2_ent = st1_ent; st2_meas = st1_meas; st2_fl = st1_fl;
      st1_cap = cap;
      st1_ent = {sof, 10'(m_hcnt - H_START), 10'(m_vcnt - V_START), rgb};
      st1_meas = vs_e;
      st1_fl   = m_vcnt;

      if (hs_e) begin
         exp_line_len = (m_hcnt + 1 > 4095) ? 4095 : m_hcnt + 1;
         m_hcnt = 0;
      end else if (m_hcnt < 4095) begin
         m_hcnt++;
      end
      if (vs_e) begin
         m_vcnt = 0;
         m_synced = 1;
      end else if (hs_e && m_vcnt < 2047) begin
         m_vcnt++;
      end
      m_hs_prev = hs_a;
      m_vs_prev = vs_a;

      gh++;
      if (gh == H_TOTAL) begin
         gh = 0;
         gv = (gv + 1) % V_TOTAL;
      end
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge fclk);
         #1;
         drive_cycle();
      end
   endtask

   task automatic run_until(input int v, input int h);
      int guard = 0;
      while (!(gv == v && gh == h) && guard < 2 * H_TOTAL * V_TOTAL) begin
         run_cycles(1);
         guard++;
      end
      check("raster_position", 32'(gv * H_TOTAL + gh), 32'(v * H_TOTAL + h));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pix"},  32'({pix_valid, pix_data, pix_x, pix_y, pix_sof}), 32'd0);
      check({tag, "_meas"}, 32'({line_len, frame_lines, meas_stb, overflow}), 32'd0);
   endtask

   // Scoreboard: compare against the model, then apply the FIFO event of the next edge.
   always @(negedge fclk) begin
      if (!rst) begin
         check("pix_valid", 32'(pix_valid), 32'(exp_q.size() > 0));
         if (exp_q.size() > 0) begin
            check("head_entry", 32'({pix_sof, pix_x, pix_y, pix_data}), 32'(exp_q[0]));
         end
         check("overflow", 32'(overflow), 32'(exp_ovf));
         check("meas_stb", 32'(meas_stb), 32'(mon_meas));
         if (mon_meas) begin
            check("frame_lines", 32'(frame_lines), 32'(mon_fl));
            $display("meas: frame_lines=%0d line_len=%0d", frame_lines, line_len);
         end
         if (pix_valid && pix_ready) begin
            pop_cnt++;
            if (pix_sof) sof_cnt++;
         end
         mon_pop = (exp_q.size() > 0) && pix_ready;
         if (mon_pop) void'(exp_q.pop_front());
         if (st2_cap) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(st2_ent);
            else exp_ovf = 1'b1;
         end
         mon_meas = st2_meas;
         mon_fl   = st2_fl;
      end
   end

   initial begin
      rst = 1'b1;
      vhsync = ~SYNC_POL; vvsync = ~SYNC_POL;
      {vred, vgrn, vblu} = '0;
      pix_ready = 1'b1;
      model_reset();
      exp_line_len = 0;
      gh = 0; gv = 3; vs_en = 0; vs_off = 50; ready_mode = 1; rgb_mode = 0;
      pop_cnt = 0; sof_cnt = 0;

      repeat (3) @(posedge fclk);
      #1;
      check_all_zero("reset");
      @(posedge fclk);
      #1;
      rst = 1'b0;
      drive_cycle();

      // Syncs running, vsync held inactive: nothing may be captured
      run_until(0, 0);
      check("unsynced_frame_lines", 32'(frame_lines), 32'd0);
      check("unsynced_pops", 32'(pop_cnt), 32'd0);
      $display("phase unsynced done");

      // Normal frames, the last one with coincident hsync/vsync edges
      vs_en = 1;
      pop_cnt = 0; sof_cnt = 0;
      for (int f = 0; f < 4; f++) begin
         vs_off = (f == 3) ? 0 : 50;
         run_cycles(H_TOTAL * V_TOTAL);
      end
      vs_off = 50;
      check("entries_per_4_frames", 32'(pop_cnt), 32'(4 * H_WIDTH * V_HEIGHT));
      check("sof_count", 32'(sof_cnt), 32'd4);
      check("line_len", 32'(line_len), 32'(exp_line_len));
      check("line_len_total", 32'(line_len), 32'(H_TOTAL));
      $display("phase streaming done: entries=%0d", pop_cnt);

      // Full FIFO popped exactly while captures keep arriving
      ready_mode = 2; rgb_mode = 1;
      run_cycles(H_TOTAL * V_TOTAL);
      ready_mode = 1;
      check("full_pop_no_overflow", 32'(overflow), 32'd0);
      $display("phase full-with-pop done");

      // Stalled consumer: entries beyond the FIFO are dropped
      ready_mode = 0;
      run_cycles(H_TOTAL * V_TOTAL);
      ready_mode = 1;
      run_cycles(H_TOTAL);
      check("overflow_sticky", 32'(overflow), 32'd1);
      check("drained_valid", 32'(pix_valid), 32'd0);
      $display("phase overflow done");

      // Asynchronous reset in the middle of a captured line
      run_until(V_START + 1, 40);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      model_reset();
      @(posedge fclk);
      #1;
      rst = 1'b0;
      drive_cycle();
      pop_cnt = 0;
      run_until(0, 0);
      check("no_capture_before_vsync", 32'(pop_cnt), 32'd0);
      run_cycles(H_TOTAL * V_TOTAL + H_TOTAL);
      check("capture_resumed", 32'(pop_cnt), 32'(H_WIDTH * V_HEIGHT));
      $display("phase mid-line reset done");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Synthesizable capture stage downstream of the top-level video outputs (vhsync, vvsync, vred, vgrn, vblu). Sits beside the frame pixel dumper in simulation and on the FPGA debug path.
- Recovers horizontal and vertical position from the syncs and measures line length and frame height.
- Emits windowed pixels with coordinates through a small valid/ready FIFO, so a slow consumer (pixel dumper, SPI readback) can apply backpressure.

Parameters:
SYNC_POL, 0, level of vhsync/vvsync that means "sync active" (0 = active-low)
H_START, 144, first captured hcnt value after hsync leading edge
H_WIDTH, 640, captured pixels per line
V_START, 40, first captured line (vcnt) after vsync leading edge
V_HEIGHT, 480, captured lines per frame
FIFO_DEPTH, 4, output FIFO entries (power of 2)

Ports:
fclk  in  1  system clock, one video sample per cycle
rst  in  1  asynchronous active-high reset
vhsync  in  1  horizontal sync from top
vvsync  in  1  vertical sync from top
vred  in  2  red
vgrn  in  2  green
vblu  in  2  blue
pix_ready  in  1  consumer accepts head entry
pix_valid  out  1  FIFO head valid
pix_data  out  6  {red,grn,blu}
pix_x  out  10  x within window
pix_y  out  10  y within window
pix_sof  out  1  entry is pixel (0,0) of a frame
line_len  out  12  fclks between last two hsync leading edges
frame_lines  out  11  lines between last two vsync leading edges
meas_stb  out  1  one-cycle pulse when frame_lines updates
overflow  out  1  sticky: a pixel was dropped

Behaviour:
- Reset (async, rst=1) clears all state.
  - Outputs: pix_valid=0, pix_data/x/y=0, pix_sof=0, line_len=0, frame_lines=0, meas_stb=0, overflow=0.
  - Internal: hcnt=0, vcnt=0, synced=0, FIFO empty.
- Reset mid-frame drops FIFO contents. After release, capture waits for the next vsync edge.
- Input stage: all six video inputs are registered once. All logic below uses the registered copies.
- Sync active = (registered sync == SYNC_POL). Leading edge = inactive in the previous cycle and active in the current cycle.
- hcnt (12 bit):
  - hsync leading edge: hcnt<=0 and line_len<=hcnt+1.
  - Otherwise hcnt+1, saturating at 4095. line_len saturates at 4095.
- vcnt (11 bit):
  - hsync leading edge: vcnt+1, saturating at 2047.
  - vsync leading edge: frame_lines<=vcnt, vcnt<=0, meas_stb=1 for that cycle, synced<=1.
  - Both edges in the same cycle: vsync wins, so vcnt<=0. hcnt<=0 and line_len updates as normal.
- Capture condition, all in the same cycle:
  - synced=1;
  - H_START<=hcnt<H_START+H_WIDTH;
  - V_START<=vcnt<V_START+V_HEIGHT;
  - neither sync active.
- A captured entry holds x=hcnt-H_START, y=vcnt-V_START, sof=(x==0 && y==0), and data=registered rgb.
- Before the first vsync edge after reset, nothing is captured.
- FIFO:
  - push = capture condition.
  - pop = pix_valid & pix_ready.
  - pix_valid = !empty. pix_* outputs show the head entry directly (show-ahead).
  - Push when full with no pop: entry dropped, overflow<=1, held until rst.
  - Push when full with a simultaneous pop: push accepted, no drop.
  - Pop when empty: ignored.
- Latency: video input to pix_valid is 2 fclk (input register + FIFO write) when the FIFO is empty.
- Pointers wrap modulo FIFO_DEPTH. The fill count is one bit wider than the pointers.

Test Plan:
- Synthetic timing (800 fclk per line with 96-cycle low hsync; 525 lines with vsync low for 2 lines); run 2 frames -> line_len=800, frame_lines=525, exactly one meas_stb pulse per vsync edge (first pulse reports the partial count since reset).
- Drive rgb=hcnt[5:0], pix_ready=1 -> first entry after the first vsync edge is x=0, y=0, sof=1, data=6'd16. Last pixel of a line is x=639. Exactly 640×480 entries per frame; the second entry has sof=0.
- pix_ready=0 during a line -> 4 entries held with values unchanged, 5th pixel dropped, overflow=1. Overflow stays 1 after pix_ready=1 drains the FIFO.
- FIFO full, then pix_ready=1 exactly on a capture cycle -> no drop, overflow stays 0, entry order preserved.
- Syncs running but vsync held inactive after reset -> pix_valid stays 0 and frame_lines=0. The first vsync edge enables capture from line V_START.
- hsync and vsync leading edges in the same cycle -> vcnt=0 and hcnt=0 next cycle. Assert rst mid-line -> all outputs 0 immediately (async), FIFO empty, no capture until the next vsync edge.
